// File: rtl/sink_fifo.sv
// sink_fifo: receiving end of a two-phase req/ack flit link.
// Flits addressed to ID are buffered in a first-word-fall-through FIFO
// and drained on a valid/ready port. Misaddressed flits are acknowledged
// and dropped, and they are counted.
module sink_fifo #(
    parameter int ID               = 0,
    parameter int SIZE             = 8,
    parameter int DESTINATION_BITS = 4,
    parameter int DEPTH            = 4,
    parameter int ACK_DELAY        = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req,
    output logic                         ack,
    input  logic [SIZE-1:0]              data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SIZE-DESTINATION_BITS-1:0] out_payload,
    output logic [15:0]                  flits_received,
    output logic [15:0]                  misrouted,
    output logic                         error
);
    localparam int PW = SIZE - DESTINATION_BITS;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, STALL} state_t;

    state_t        state;
    logic [7:0]    dly_cnt;
    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [PW-1:0] payload_in;
    logic [PW-1:0] head_next;
    logic          pending;
    logic          match;
    logic          full;
    logic          attempt;
    logic          push;
    logic          drop;
    logic          pop;

    assign pending    = req ^ ack;
    assign match      = data[DESTINATION_BITS-1:0] == DESTINATION_BITS'(ID);
    assign payload_in = data[SIZE-1:DESTINATION_BITS];
    assign full       = count == CW'(DEPTH);
    assign out_valid  = count != '0;
    assign pop        = out_valid && out_ready;

    // Decide whether this edge performs the accept action on the pending flit
    always_comb begin
        attempt = 1'b0;
        case (state)
            IDLE:    attempt = pending && (ACK_DELAY == 0);
            WAIT:    attempt = dly_cnt == '0;
            STALL:   attempt = 1'b1;
            default: attempt = 1'b0;
        endcase
        push = attempt && match && !full;
        drop = attempt && !match;
    end

    // Handshake FSM, acknowledge toggle and statistics counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            dly_cnt        <= '0;
            ack            <= 1'b0;
            flits_received <= '0;
            misrouted      <= '0;
            error          <= 1'b0;
        end else begin
            if (push || drop)
                ack <= ~ack;
            if (push && flits_received != '1)
                flits_received <= flits_received + 16'd1;
            if (drop) begin
                error <= 1'b1;
                if (misrouted != '1)
                    misrouted <= misrouted + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (pending && ACK_DELAY != 0) begin
                        dly_cnt <= 8'(ACK_DELAY - 1);
                        state   <= WAIT;
                    end else if (attempt && match && full) begin
                        state <= STALL;
                    end
                end
                WAIT: begin
                    if (dly_cnt == '0)
                        state <= (match && full) ? STALL : IDLE;
                    else
                        dly_cnt <= dly_cnt - 8'd1;
                end
                STALL: begin
                    if (push)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Next-cycle FIFO occupancy and head word for the registered output
    always_comb begin
        rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
        head_next = out_payload;
        if (count_next != '0) begin
            // Nothing left after the pop: the new head is the word being written now
            if (count == CW'(pop))
                head_next = payload_in;
            else
                head_next = mem[rd_next];
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= payload_in;
    end

    // FIFO pointers, occupancy and head register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_payload <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr      <= rd_next;
            count       <= count_next;
            out_payload <= head_next;
        end
    end
endmodule

// File: tb/tb_sink_fifo.sv
// tb_sink_fifo: two sink instances (ACK_DELAY 0 and 3, ID 3, DEPTH 4)
// checked every cycle against a queue-based model, plus directed checks.
module tb_sink_fifo;
    logic        clk = 1'b0;
    logic        reset;
    logic        req [2];
    logic        ack [2];
    logic [7:0]  data [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [3:0]  out_payload [2];
    logic [15:0] flits [2];
    logic [15:0] mis [2];
    logic        error [2];

    int nvec = 0;
    int nmis = 0;
    int rmode [2];

    // model state
    logic        m_ack [2];
    logic [3:0]  mq [2][$];
    logic [3:0]  mpop [2][$];
    int          m_flits [2];
    int          m_mis [2];
    int          m_err [2];
    int          m_seen [2];
    logic [3:0]  m_last [2];

    sink_fifo #(.ID(3), .SIZE(8), .DESTINATION_BITS(4), .DEPTH(4), .ACK_DELAY(0)) dut0 (
        .clk(clk), .reset(reset), .req(req[0]), .ack(ack[0]), .data(data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_payload(out_payload[0]),
        .flits_received(flits[0]), .misrouted(mis[0]), .error(error[0]));

    sink_fifo #(.ID(3), .SIZE(8), .DESTINATION_BITS(4), .DEPTH(4), .ACK_DELAY(3)) dut1 (
        .clk(clk), .reset(reset), .req(req[1]), .ack(ack[1]), .data(data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_payload(out_payload[1]),
        .flits_received(flits[1]), .misrouted(mis[1]), .error(error[1]));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dly(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ack[k]   = 1'b0;
            mq[k].delete();
            mpop[k].delete();
            m_flits[k] = 0;
            m_mis[k]   = 0;
            m_err[k]   = 0;
            m_seen[k]  = 0;
            m_last[k]  = 4'd0;
        end
    endtask

    // One clock edge of the link: accept after the delay, retry while full, pop on ready
    task automatic model_step(input int k);
        int         sz;
        logic       do_pop;
        logic       do_push;
        logic [3:0] pl;
        sz      = mq[k].size();
        do_pop  = (sz > 0) && out_ready[k];
        do_push = 1'b0;
        pl      = data[k][7:4];
        if (req[k] != m_ack[k]) begin
            m_seen[k]++;
            if (m_seen[k] > dly(k)) begin
                if (data[k][3:0] != 4'd3) begin
                    m_ack[k]  = ~m_ack[k];
                    m_err[k]  = 1;
                    if (m_mis[k] < 65535) m_mis[k]++;
                    m_seen[k] = 0;
                end else if (sz < 4) begin
                    do_push   = 1'b1;
                    m_ack[k]  = ~m_ack[k];
                    if (m_flits[k] < 65535) m_flits[k]++;
                    m_seen[k] = 0;
                end
            end
        end
        if (do_pop) mpop[k].push_back(mq[k].pop_front());
        if (do_push) mq[k].push_back(pl);
        if (mq[k].size() > 0) m_last[k] = mq[k][0];
    endtask

    // Advance the model on every active edge while out of reset
    always @(posedge clk) begin
        if (reset === 1'b1)
            for (int k = 0; k < 2; k++) model_step(k);
    end

    // Compare every DUT output against the model just after each edge
    always @(posedge clk) begin
        #1;
        if (reset === 1'b1) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("ack%0d", k), ack[k], m_ack[k]);
                chk($sformatf("out_valid%0d", k), out_valid[k], mq[k].size() > 0);
                chk($sformatf("out_payload%0d", k), out_payload[k], m_last[k]);
                chk($sformatf("flits%0d", k), flits[k], m_flits[k]);
                chk($sformatf("misrouted%0d", k), mis[k], m_mis[k]);
                chk($sformatf("error%0d", k), error[k], m_err[k]);
            end
        end
    end

    // Drive the consumer ready lines according to the per-instance mode
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            case (rmode[k])
                0:       out_ready[k] = 1'b0;
                1:       out_ready[k] = 1'b1;
                default: out_ready[k] = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send(input int k, input logic [7:0] d);
        int i;
        i = 0;
        @(negedge clk);
        while (req[k] !== ack[k] && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (i >= 300) chk($sformatf("handshake_timeout%0d", k), req[k] ^ ack[k], 0);
        data[k] = d;
        req[k]  = ~req[k];
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int old;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req[k]  = 1'b0;
            data[k] = 8'h00;
            rmode[k] = 1;
        end
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ack%0d", k), ack[k], 0);
            chk($sformatf("rst_valid%0d", k), out_valid[k], 0);
            chk($sformatf("rst_payload%0d", k), out_payload[k], 0);
            chk($sformatf("rst_flits%0d", k), flits[k], 0);
            chk($sformatf("rst_error%0d", k), error[k], 0);
        end
        @(negedge clk);
        reset = 1'b1;
        cycles(3);

        // single flit 0x53, ack one edge later, output pulses
        send(0, 8'h53);
        cycles(1);
        chk("t1_ack", ack[0], 1);
        chk("t1_valid", out_valid[0], 1);
        chk("t1_payload", out_payload[0], 5);
        chk("t1_flits", flits[0], 1);
        cycles(1);
        chk("t1_valid_gone", out_valid[0], 0);

        // fill with out_ready low, stall, then drain in order
        rmode[0] = 0;
        cycles(2);
        mpop[0].delete();
        for (int p = 1; p <= 5; p++) send(0, {4'(p), 4'd3});
        cycles(3);
        chk("t2_stalled", req[0] ^ ack[0], 1);
        chk("t2_flits", flits[0], 5);
        chk("t2_head", out_payload[0], 1);
        chk("t2_model_depth", mq[0].size(), 4);
        rmode[0] = 1;
        send(0, 8'h63);
        cycles(12);
        chk("t2_drained", mpop[0].size(), 6);
        for (int p = 0; p < 6; p++)
            chk($sformatf("t2_order%0d", p), (mpop[0].size() > p) ? mpop[0][p] : 15, p + 1);
        chk("t2_flits_end", flits[0], 7);

        // misrouted flit is acked and dropped, next one delivered
        send(0, 8'h75);
        cycles(3);
        chk("t3_misrouted", mis[0], 1);
        chk("t3_error", error[0], 1);
        chk("t3_valid", out_valid[0], 0);
        chk("t3_acked", req[0] ^ ack[0], 0);
        send(0, 8'h93);
        cycles(1);
        chk("t3_valid_next", out_valid[0], 1);
        chk("t3_payload_next", out_payload[0], 9);
        chk("t3_flits", flits[0], 8);

        // ACK_DELAY=3: ack four edges after req
        send(1, 8'h43);
        old = ack[1];
        n = 0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (ack[1] !== old && n == 0) n = e;
        end
        chk("t4_ack_edges", n, 4);
        chk("t4_flits", flits[1], 1);

        // async reset in the middle of WAIT with two entries buffered
        rmode[1] = 0;
        cycles(2);
        send(1, 8'h13);
        send(1, 8'h23);
        send(1, 8'h33);
        @(posedge clk);
        #3;
        chk("t5_pre_valid", out_valid[1], 1);
        chk("t5_pre_model", mq[1].size(), 2);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            req[k]  = 1'b0;
            data[k] = 8'h00;
        end
        #1;
        chk("t5_ack", ack[1], 0);
        chk("t5_valid", out_valid[1], 0);
        chk("t5_flits1", flits[1], 0);
        chk("t5_flits0", flits[0], 0);
        chk("t5_mis0", mis[0], 0);
        chk("t5_err0", error[0], 0);
        chk("t5_payload", out_payload[1], 0);
        @(negedge clk);
        reset = 1'b1;
        rmode[1] = 1;
        send(1, 8'hA3);
        cycles(6);
        chk("t5_after_flits", flits[1], 1);
        chk("t5_after_pop", (mpop[1].size() > 0) ? mpop[1][0] : 15, 10);

        // saturation of flits_received
        @(negedge clk);
        force dut0.flits_received = 16'hFFFF;
        m_flits[0] = 65535;
        #1;
        release dut0.flits_received;
        mpop[0].delete();
        send(0, 8'hB3);
        cycles(3);
        chk("t6_saturated", flits[0], 65535);
        chk("t6_delivered", (mpop[0].size() > 0) ? mpop[0][0] : 15, 11);

        // randomized traffic with random back-pressure on both instances
        rmode[0] = 2;
        rmode[1] = 2;
        fork
            for (int i = 0; i < 150; i++)
                send(0, {4'($urandom), ($urandom_range(0, 5) == 0) ? 4'($urandom_range(4, 15)) : 4'd3});
            for (int i = 0; i < 150; i++)
                send(1, {4'($urandom), ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 2)) : 4'd3});
        join
        rmode[0] = 1;
        rmode[1] = 1;
        cycles(30);
        chk("final_empty0", out_valid[0], 0);
        chk("final_empty1", out_valid[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
